nn_layer_sequencer: RTL and testbench

- Control FSM that drives the two fully-connected layers of the MNIST accelerator over the 64-bank input/output SRAM and the w1/w2 weight SRAMs.
- Issues one row per cycle: row index, weight address for long and short banks, bank-valid mask and MAC first/last strobes.
- Tracks the MAC pipeline latency and tags each finished neuron so its result can be written back.
- Runs layer 1 (784→200), drains the pipeline, runs layer 2 (200→10), drains, then pulses done.

---
 rtl/nn_layer_sequencer.sv | 148 ++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: row/neuron sequencer for the two FC layers; NN_SEQ_PERF_EN adds perf counters
module nn_layer_sequencer #(
    parameter int BANKS   = 64,
    parameter int L1_IN   = 784,
    parameter int L1_OUT  = 200,
    parameter int L2_IN   = 200,
    parameter int L2_OUT  = 10,
    parameter int MAC_LAT = 3,
    parameter int AW      = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             issue,
    output logic             layer,
    output logic [3:0]       row,
    output logic [7:0]       neuron,
    output logic [AW-1:0]    waddr_long,
    output logic [AW-1:0]    waddr_short,
    output logic [BANKS-1:0] bank_mask,
    output logic             mac_first,
    output logic             mac_last,
    output logic             result_valid,
    output logic             result_layer,
    output logic [7:0]       result_idx
`ifdef NN_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stalls
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
    localparam int L1_RS = L1_IN / BANKS;
    localparam int L1_NL = L1_IN % BANKS;
    localparam int L1_RL = L1_RS + ((L1_NL > 0) ? 1 : 0);
    localparam int L2_RS = L2_IN / BANKS;
    localparam int L2_NL = L2_IN % BANKS;
    localparam int L2_RL = L2_RS + ((L2_NL > 0) ? 1 : 0);

    typedef struct packed {
        logic       last;
        logic       layer;
        logic [7:0] k;
    } tag_t;

    logic [1:0]    state;
    logic [AW-1:0] base_long, base_short;
    logic [3:0]    rows_l, rows_s;
    logic [7:0]    nlong, last_k;
    logic          row_end;
    tag_t          pipe [MAC_LAT];

    // Per-layer geometry, issue strobes, addresses and the pipeline head
    always_comb begin
        rows_l       = layer ? 4'(L2_RL) : 4'(L1_RL);
        rows_s       = layer ? 4'(L2_RS) : 4'(L1_RS);
        nlong        = layer ? 8'(L2_NL) : 8'(L1_NL);
        last_k       = layer ? 8'(L2_OUT - 1) : 8'(L1_OUT - 1);
        busy         = (state == S_RUN) || (state == S_DRAIN);
        done         = state == S_DONE;
        issue        = (state == S_RUN) && !stall;
        row_end      = row == rows_l - 4'd1;
        mac_first    = issue && (row == 4'd0);
        mac_last     = issue && row_end;
        waddr_long   = base_long + AW'(row);
        waddr_short  = base_short + AW'(row);
        bank_mask    = (state != S_RUN) ? '0 : (row < rows_s) ? '1 : ~({BANKS{1'b1}} << nlong);
        result_valid = pipe[MAC_LAT-1].last && !stall;
        result_layer = pipe[MAC_LAT-1].layer;
        result_idx   = pipe[MAC_LAT-1].k;
    end

    // Control FSM with row/neuron counters and incremental weight-address bases
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            layer      <= 1'b0;
            row        <= '0;
            neuron     <= '0;
            base_long  <= '0;
            base_short <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        layer      <= 1'b0;
                        row        <= '0;
                        neuron     <= '0;
                        base_long  <= '0;
                        base_short <= '0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        row <= row_end ? 4'd0 : row + 4'd1;
                        if (row_end && neuron == last_k) begin
                            state      <= S_DRAIN;
                            neuron     <= '0;
                            base_long  <= '0;
                            base_short <= '0;
                        end else if (row_end) begin
                            neuron     <= neuron + 8'd1;
                            base_long  <= base_long + AW'(rows_l);
                            base_short <= base_short + AW'(rows_s);
                        end
                    end
                end
                S_DRAIN: begin
                    if (result_valid && result_layer == layer && result_idx == last_k) begin
                        state <= layer ? S_DONE : S_RUN;
                        layer <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    layer <= 1'b0;
                end
            endcase
        end
    end

    // MAC latency pipeline of {last, layer, k}, frozen while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAC_LAT; i++) pipe[i] <= '0;
        end else if (!stall) begin
            for (int i = MAC_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= '{last: mac_last, layer: layer, k: neuron};
        end
    end

`ifdef NN_SEQ_PERF_EN
    // Busy-cycle and stalled-cycle counters, cleared when a run is accepted
    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE && start)) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
            perf_stalls <= perf_stalls + 32'(stall);
        end
    end
`endif
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: position-based model check of the sequencer at MAC_LAT 3 and 1
module tb_nn_layer_sequencer;
    localparam int BANKS = 64, L1_IN = 784, L1_OUT = 200, L2_IN = 200, L2_OUT = 10;
    localparam int R1S = L1_IN / BANKS, N1 = L1_IN % BANKS, R1L = R1S + ((N1 > 0) ? 1 : 0);
    localparam int R2S = L2_IN / BANKS, N2 = L2_IN % BANKS, R2L = R2S + ((N2 > 0) ? 1 : 0);

    typedef struct packed {
        logic        busy, done, issue, layer;
        logic [3:0]  row;
        logic [7:0]  neuron;
        logic [11:0] wl, ws;
        logic [63:0] mask;
        logic        first, last, rv, rl;
        logic [7:0]  ri;
        logic        run, drain;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
    logic busy3, done3, issue3, layer3, first3, last3, rv3, rl3;
    logic busy1, done1, issue1, layer1, first1, last1, rv1, rl1;
    logic [3:0]  row3, row1;
    logic [7:0]  neuron3, neuron1, ri3, ri1;
    logic [11:0] wl3, ws3, wl1, ws1;
    logic [63:0] mask3, mask1;
`ifdef NN_SEQ_PERF_EN
    logic [31:0] pc3, ps3, pc1, ps1;
`endif
    exp_t act3, act1, m;
    int checks = 0, passes = 0, cyc = 0, p3 = 0, p1 = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    nn_layer_sequencer #(.MAC_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy3), .done(done3), .issue(issue3), .layer(layer3),
        .row(row3), .neuron(neuron3), .waddr_long(wl3), .waddr_short(ws3),
        .bank_mask(mask3), .mac_first(first3), .mac_last(last3),
        .result_valid(rv3), .result_layer(rl3), .result_idx(ri3)
`ifdef NN_SEQ_PERF_EN
        , .perf_cycles(pc3), .perf_stalls(ps3)
`endif
    );

    nn_layer_sequencer #(.MAC_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy1), .done(done1), .issue(issue1), .layer(layer1),
        .row(row1), .neuron(neuron1), .waddr_long(wl1), .waddr_short(ws1),
        .bank_mask(mask1), .mac_first(first1), .mac_last(last1),
        .result_valid(rv1), .result_layer(rl1), .result_idx(ri1)
`ifdef NN_SEQ_PERF_EN
        , .perf_cycles(pc1), .perf_stalls(ps1)
`endif
    );

    assign act3 = {busy3, done3, issue3, layer3, row3, neuron3, wl3, ws3, mask3, first3, last3, rv3, rl3, ri3, 2'b00};
    assign act1 = {busy1, done1, issue1, layer1, row1, neuron1, wl1, ws1, mask1, first1, last1, rv1, rl1, ri1, 2'b00};

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, a, e, $time);
    endtask

    // Position 1 is the first RUN cycle after start; position advances on each unstalled busy cycle
    function automatic int total(input int lat);
        return L1_OUT * R1L + L2_OUT * R2L + 2 * lat + 1;
    endfunction

    function automatic int nxt(input int p, input int lat, input logic st, input logic go);
        if (p == 0) return go ? 1 : 0;
        if (p == total(lat)) return 0;
        return st ? p : p + 1;
    endfunction

    function automatic bit dec(input int p, input int lat, output int lay, output int k, output int j);
        int i1, d1, e2, n;
        i1 = L1_OUT * R1L;
        d1 = i1 + lat;
        e2 = d1 + L2_OUT * R2L;
        lay = (p > d1) ? 1 : 0;
        k = 0;
        j = 0;
        if (p >= 1 && p <= i1) begin
            n = p - 1; k = n / R1L; j = n % R1L;
            return 1'b1;
        end
        if (p > d1 && p <= e2) begin
            n = p - d1 - 1; k = n / R2L; j = n % R2L;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic exp_t model(input int p, input int lat, input logic st);
        exp_t e;
        int lay, k, j, rl, rs, nl, ql, qk, qj;
        e = '0;
        if (p == 0) return e;
        if (p == total(lat)) begin
            e.done = 1'b1;
            return e;
        end
        e.busy = 1'b1;
        if (dec(p, lat, lay, k, j)) begin
            rl = lay ? R2L : R1L;
            rs = lay ? R2S : R1S;
            nl = lay ? N2 : N1;
            e.run    = 1'b1;
            e.row    = 4'(j);
            e.neuron = 8'(k);
            e.wl     = 12'(k * rl + j);
            e.ws     = 12'(k * rs + j);
            e.mask   = (j < rs) ? '1 : (64'd1 << nl) - 64'd1;
            e.issue  = !st;
            e.first  = !st && j == 0;
            e.last   = !st && j == rl - 1;
        end else begin
            e.drain = 1'b1;
        end
        e.layer = 1'(lay);
        if (dec(p - lat, lat, ql, qk, qj) && qj == (ql ? R2L : R1L) - 1) begin
            e.rv = !st;
            e.rl = 1'(ql);
            e.ri = 8'(qk);
        end
        return e;
    endfunction

    task automatic cmp(input string d, input exp_t a, input exp_t e);
        chk({d, " busy"}, 64'(a.busy), 64'(e.busy));
        chk({d, " done"}, 64'(a.done), 64'(e.done));
        chk({d, " issue"}, 64'(a.issue), 64'(e.issue));
        chk({d, " mac_first"}, 64'(a.first), 64'(e.first));
        chk({d, " mac_last"}, 64'(a.last), 64'(e.last));
        chk({d, " result_valid"}, 64'(a.rv), 64'(e.rv));
        if (e.run || e.drain) chk({d, " layer"}, 64'(a.layer), 64'(e.layer));
        if (e.run) begin
            chk({d, " row"}, 64'(a.row), 64'(e.row));
            chk({d, " neuron"}, 64'(a.neuron), 64'(e.neuron));
            chk({d, " waddr_long"}, 64'(a.wl), 64'(e.wl));
            chk({d, " waddr_short"}, 64'(a.ws), 64'(e.ws));
            chk({d, " bank_mask"}, a.mask, e.mask);
        end
        if (e.rv) begin
            chk({d, " result_layer"}, 64'(a.rl), 64'(e.rl));
            chk({d, " result_idx"}, 64'(a.ri), 64'(e.ri));
        end
    endtask

    // Model position tracking
    always @(posedge clk) begin
        p3 <= reset ? 0 : nxt(p3, 3, stall, start);
        p1 <= reset ? 0 : nxt(p1, 1, stall, start);
    end

    // Every-cycle comparison of both builds against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("lat3", act3, model(p3, 3, stall));
            cmp("lat1", act1, model(p1, 1, stall));
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
    endtask

    initial begin
        m = model(14, 3, 1'b0);
        chk("pin wl k1j0", 64'(m.wl), 64'd13);
        chk("pin ws k1j0", 64'(m.ws), 64'd12);
        m = model(26, 3, 1'b0);
        chk("pin mask k1j12", m.mask, 64'hFFFF);
        m = model(16, 3, 1'b0);
        chk("pin first result", 64'(m.rv), 64'd1);
        m = model(2643, 3, 1'b0);
        chk("pin l2 wl", 64'(m.wl), 64'd39);
        chk("pin l2 mask", m.mask, 64'hFF);
        m = model(2647, 3, 1'b0);
        chk("pin done", 64'(m.done), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst busy", 64'(busy3), 64'd0);
        chk("rst row", 64'(row3), 64'd0);
        chk("rst mask", mask3, 64'd0);
        chk("rst waddr", 64'(wl3), 64'd0);
        chk("rst rv", 64'(rv1), 64'd0);

        start_run();
        go_to(14); #1;
        chk("A k1j0 waddr_long", 64'(wl3), 64'd13);
        chk("A k1j0 waddr_short", 64'(ws3), 64'd12);
        chk("A k1j0 mac_first", 64'(first3), 64'd1);
        chk("A lat1 first result", 64'(rv1), 64'd1);
        go_to(16); #1;
        chk("A first result", 64'(rv3), 64'd1);
        chk("A first result idx", 64'(ri3), 64'd0);
        go_to(26); #1;
        chk("A k1j12 mask", mask3, 64'hFFFF);
        chk("A k1j12 mac_last", 64'(last3), 64'd1);
        chk("A k1j12 waddr_long", 64'(wl3), 64'd25);
        go_to(500);
        start = 1'b1;
        go_to(501);
        start = 1'b0;
        go_to(2642); #1;
        chk("A l2 j2 mask", mask3, 64'hFFFF_FFFF_FFFF_FFFF);
        go_to(2643); #1;
        chk("A l2 k9j3 waddr_long", 64'(wl3), 64'd39);
        chk("A l2 k9j3 waddr_short", 64'(ws3), 64'd30);
        chk("A l2 k9j3 mask", mask3, 64'hFF);
        chk("A lat1 done", 64'(done1), 64'd1);
        go_to(2646); #1;
        chk("A done early", 64'(done3), 64'd0);
        go_to(2647); #1;
        chk("A done", 64'(done3), 64'd1);
        chk("A busy at done", 64'(busy3), 64'd0);
        go_to(2650);

        start_run();
        go_to(658);
        stall = 1'b1;
        go_to(660); #1;
        chk("B frozen row", 64'(row3), 64'd7);
        chk("B frozen neuron", 64'(neuron3), 64'd50);
        chk("B stalled issue", 64'(issue3), 64'd0);
        go_to(663);
        stall = 1'b0;
        #1;
        chk("B resume issue", 64'(issue3), 64'd1);
        chk("B resume row", 64'(row3), 64'd7);
        go_to(664); #1;
        chk("B next row", 64'(row3), 64'd8);
        go_to(2648); #1;
        chk("B lat1 done", 64'(done1), 64'd1);
        go_to(2651); #1;
        chk("B done early", 64'(done3), 64'd0);
        go_to(2652); #1;
        chk("B done", 64'(done3), 64'd1);
`ifdef NN_SEQ_PERF_EN
        chk("B perf_stalls", 64'(ps3), 64'd5);
        chk("B perf_cycles", 64'(pc3), 64'd2651);
        chk("B lat1 perf_cycles", 64'(pc1), 64'd2647);
`endif
        go_to(2655);

        start_run();
        go_to(1000);
        reset = 1'b1;
        go_to(1001);
        reset = 1'b0;
        #1;
        chk("C rst busy", 64'(busy3), 64'd0);
        chk("C rst issue", 64'(issue3), 64'd0);
        chk("C rst row", 64'(row3), 64'd0);
        chk("C rst neuron", 64'(neuron3), 64'd0);
        chk("C rst waddr", 64'(wl3), 64'd0);
        chk("C rst mask", mask3, 64'd0);
        chk("C rst lat1 busy", 64'(busy1), 64'd0);
        go_to(1020); #1;
        chk("C no done", 64'(done3), 64'd0);
        start_run();
        #1;
        chk("C restart row", 64'(row3), 64'd0);
        chk("C restart neuron", 64'(neuron3), 64'd0);
        chk("C restart layer", 64'(layer3), 64'd0);
        chk("C restart issue", 64'(issue3), 64'd1);
        go_to(2647); #1;
        chk("C done", 64'(done3), 64'd1);
        go_to(2650);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
